pwm_capture: RTL and testbench

- Measures an incoming PWM waveform, such as the output of the team's `pulse_generator`, and reports three results:
  - period, as clk cycles between consecutive rising edges;
  - high time, as clk cycles the input stays high;
  - a quantized duty code matching the generator's duty modes 0–4.
- It is the receive-side counterpart used for loopback checks and for reading external PWM sources.
- Detects a stuck input with a timeout.

---
 rtl/pwm_capture.sv | 169 ++++++++++++++++
 tb/tb_pwm_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time between rising edges, flags a stuck input after TIMEOUT cycles.
// Optional duty quantizer is built only when PWM_CAP_DUTY_CLASS_EN is defined; otherwise duty_mode is tied to 0.
module pwm_capture #(
    parameter int          CNT_W   = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             level_stuck,
    output logic [3:0]       duty_mode
);

    localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {SEEK, HIGH, LOW, STUCK} state_t;

    state_t           state, state_nxt;
    logic             sync1, s, s_d;
    logic [1:0]       arm_cnt;
    logic             armed, rise, fall;
    logic [CNT_W-1:0] cnt, hi_latch;
    logic             meas_upd, stuck_upd, stuck_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            s       <= 1'b0;
            s_d     <= 1'b0;
            arm_cnt <= 2'd0;
        end else begin
            sync1 <= pwm_in;
            s     <= sync1;
            s_d   <= s;
            if (arm_cnt != 2'd3)
                arm_cnt <= arm_cnt + 2'd1;
        end
    end

    // Arming hides the spurious edge a held-high input would show while the synchronizer fills.
    assign armed = (arm_cnt == 2'd3);
    assign rise  = armed & s & ~s_d;
    assign fall  = armed & ~s & s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            hi_latch <= '0;
        end else begin
            if (rise)
                cnt <= ONE;
            else if (cnt != TO)
                cnt <= cnt + ONE;
            if (fall)
                hi_latch <= cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= SEEK;
        else
            state <= state_nxt;
    end

    // A rise always beats the timeout; in HIGH the timeout beats a coincident fall so stuck timing stays exact.
    always_comb begin
        state_nxt = state;
        meas_upd  = 1'b0;
        stuck_upd = 1'b0;
        stuck_clr = 1'b0;
        case (state)
            SEEK: begin
                if (rise) begin
                    state_nxt = HIGH;
                end else if (cnt == TO) begin
                    state_nxt = STUCK;
                    stuck_upd = 1'b1;
                end
            end
            HIGH: begin
                if (cnt == TO) begin
                    state_nxt = STUCK;
                    stuck_upd = 1'b1;
                end else if (fall) begin
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt = HIGH;
                    meas_upd  = 1'b1;
                end else if (cnt == TO) begin
                    state_nxt = STUCK;
                    stuck_upd = 1'b1;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_nxt = HIGH;
                    stuck_clr = 1'b1;
                end
            end
            default: state_nxt = SEEK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            level_stuck <= 1'b0;
        end else begin
            valid <= meas_upd | stuck_upd;
            if (meas_upd) begin
                period    <= cnt;
                high_time <= hi_latch;
            end else if (stuck_upd) begin
                period    <= '0;
                high_time <= '0;
            end
            if (stuck_upd)
                level_stuck <= 1'b1;
            else if (stuck_clr)
                level_stuck <= 1'b0;
        end
    end

`ifdef PWM_CAP_DUTY_CLASS_EN
    // Thresholds at 1P,3P,5P,7P against 8*high round to the nearest quarter.
    logic [CNT_W+2:0] h8, p1, p3, p5, p7;
    logic [3:0]       duty_q;

    assign h8 = {hi_latch, 3'b000};
    assign p1 = {3'b000, cnt};
    assign p3 = p1 + (p1 << 1);
    assign p5 = p1 + (p1 << 2);
    assign p7 = (p1 << 3) - p1;

    always_comb begin
        duty_q = 4'd4;
        if (h8 < p1)
            duty_q = 4'd0;
        else if (h8 < p3)
            duty_q = 4'd1;
        else if (h8 < p5)
            duty_q = 4'd2;
        else if (h8 < p7)
            duty_q = 4'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            duty_mode <= 4'd0;
        else if (meas_upd)
            duty_mode <= duty_q;
        else if (stuck_upd)
            duty_mode <= s ? 4'd4 : 4'd0;
    end
`else
    assign duty_mode = 4'd0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table of steady waveforms, stuck/reset sequences, and random waveforms vs a timestamp model.
module tb_pwm_capture;

    localparam int CNT_W = 16;
    localparam int TO    = 100;
`ifdef PWM_CAP_DUTY_CLASS_EN
    localparam bit DUTY_EN = 1'b1;
`else
    localparam bit DUTY_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             pwm_in;
    logic [CNT_W-1:0] period, high_time;
    logic             valid, level_stuck;
    logic [3:0]       duty_mode;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .period(period), .high_time(high_time), .valid(valid),
        .level_stuck(level_stuck), .duty_mode(duty_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int duty_of(input int h, input int p);
        int c;
        if (!DUTY_EN) return 0;
        c = (8 * h + p) / (2 * p);
        return (c > 4) ? 4 : c;
    endfunction

    // Reference model: edge n sees the input sampled two edges earlier; edges count only from edge 4 after release.
    int  n, anchor, fall_t;
    bit  h1, h2, h3, have_rise, stuck;
    int  e_per, e_hi, e_duty;
    bit  e_valid, e_ls;

    always @(posedge clk or posedge rst) begin
        bit r, f;
        if (rst) begin
            n = 0; h1 = 0; h2 = 0; h3 = 0;
            anchor = 1; fall_t = 0; have_rise = 0; stuck = 0;
            e_per = 0; e_hi = 0; e_duty = 0; e_valid = 0; e_ls = 0;
        end else begin
            n++;
            r = h2 && !h3 && (n >= 4);
            f = !h2 && h3 && (n >= 4);
            e_valid = 0;
            if (r) begin
                if (have_rise && !stuck) begin
                    e_valid = 1;
                    e_per   = n - anchor;
                    e_hi    = fall_t - anchor;
                    e_duty  = duty_of(e_hi, e_per);
                end
                stuck = 0; e_ls = 0; anchor = n; have_rise = 1;
            end else if (!stuck && (n - anchor == TO)) begin
                e_valid = 1; e_per = 0; e_hi = 0; e_ls = 1;
                e_duty  = (DUTY_EN && h2) ? 4 : 0;
                stuck = 1; have_rise = 0;
            end
            if (f) fall_t = n;
            h3 = h2; h2 = h1; h1 = pwm_in;
        end
    end

    int cyc = 0;
    int vc = 0, sc = 0, last_vcyc = 0, prev_vcyc = 0;
    int cap_per = 0, cap_hi = 0, cap_duty = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_valid", valid, 0);
            check("rst_period", period, 0);
            check("rst_high_time", high_time, 0);
            check("rst_level_stuck", level_stuck, 0);
            check("rst_duty_mode", duty_mode, 0);
        end else begin
            check("valid", valid, e_valid);
            check("level_stuck", level_stuck, e_ls);
            check("period", period, e_per);
            check("high_time", high_time, e_hi);
            check("duty_mode", duty_mode, e_duty);
            if (valid === 1'b1) begin
                vc++;
                if (level_stuck === 1'b1) sc++;
                prev_vcyc = last_vcyc;
                last_vcyc = cyc;
                cap_per   = period;
                cap_hi    = high_time;
                cap_duty  = duty_mode;
            end
        end
    end

    task automatic drive_pwm(input int per, input int hi, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < per; i++) begin
                pwm_in = (i < hi);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int c);
        repeat (c) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        int per;
        int hi;
        int reps;
        int exp_per;
        int exp_hi;
        int exp_duty;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int   v0;
        tbl[0] = '{32, 8, 6, 32, 8, 1};
        tbl[1] = '{64, 32, 4, 64, 32, 2};
        tbl[2] = '{64, 48, 4, 64, 48, 3};
        tbl[3] = '{2, 1, 20, 2, 1, 2};
        tbl[4] = '{50, 45, 4, 50, 45, 4};
        tbl[5] = '{20, 3, 5, 20, 3, 1};
        tbl[6] = '{10, 1, 6, 10, 1, 0};

        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drive_pwm(tbl[i].per, tbl[i].hi, tbl[i].reps);
            check($sformatf("row%0d_period", i), cap_per, tbl[i].exp_per);
            check($sformatf("row%0d_high_time", i), cap_hi, tbl[i].exp_hi);
            check($sformatf("row%0d_duty", i), cap_duty, DUTY_EN ? tbl[i].exp_duty : 0);
        end

        // Held low: one stuck pulse exactly TIMEOUT cycles after the last normal valid.
        drive_pwm(32, 8, 3);
        sc = 0;
        idle(TO + 30);
        check("stuck_low_pulses", sc, 1);
        check("stuck_low_delay", last_vcyc - prev_vcyc, TO);
        check("stuck_low_flag", level_stuck, 1);
        check("stuck_low_period", period, 0);
        check("stuck_low_duty", duty_mode, 0);

        // Held high after a rise.
        sc = 0;
        pwm_in = 1'b1;
        idle(TO + 30);
        check("stuck_high_pulses", sc, 1);
        check("stuck_high_flag", level_stuck, 1);
        check("stuck_high_duty", duty_mode, DUTY_EN ? 4 : 0);

        // Resume toggling.
        drive_pwm(32, 8, 4);
        check("resume_flag", level_stuck, 0);
        check("resume_period", cap_per, 32);
        check("resume_high_time", cap_hi, 8);

        // Reset mid-HIGH with the input held high.
        pwm_in = 1'b1;
        idle(5);
        #3 rst = 1'b1;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_period", period, 0);
        check("async_rst_high_time", high_time, 0);
        check("async_rst_level_stuck", level_stuck, 0);
        check("async_rst_duty", duty_mode, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        v0 = vc;
        idle(10);
        check("post_rst_held_high_valids", vc - v0, 0);
        drive_pwm(24, 6, 3);
        check("post_rst_valids", vc - v0, 1);
        check("post_rst_period", cap_per, 24);

        // Random waveforms against the model.
        for (int k = 0; k < 40; k++) begin
            int per, hi, reps;
            per  = $urandom_range(2, 60);
            hi   = $urandom_range(0, per);
            reps = $urandom_range(1, 4);
            drive_pwm(per, hi, reps);
        end
        idle(TO + 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
